ex_mdu: RTL
===========

// Module: ex_mdu
// PURPOSE
// - Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
// - Consumes forwarded rs/rt operands and a decoded MDU op (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// - Produces architectural HI/LO and a busy flag that the hazard unit uses to stall MDU instructions.
// - Honours the exception/interrupt request `req`: an op presented in a req cycle never commits.
// PARAMETERS
// - MULT_CYCLES  5   cycles busy is high for MULT/MULTU (>=1)
// - DIV_CYCLES   10  cycles busy is high for DIV/DIVU (>=1)
// PORTS
// - clk     in   1   single clock, rising edge
// - reset   in   1   synchronous, active-high; clears all state
// - req     in   1   exception/interrupt flush; squashes this cycle's start/mthi/mtlo
// - start   in   1   issue strobe for mdu_op (one cycle per instruction)
// - mdu_op  in   3   MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO (mdu_pkg)
// - rs_val  in   32  forwarded rs operand (dividend / multiplicand / mthi/mtlo data)
// - rt_val  in   32  forwarded rt operand (divisor / multiplier)
// - busy    out  1   registered; high while a mult/div is in flight
// - hi      out  32  architectural HI, registered
// - lo      out  32  architectural LO, registered
// BEHAVIOUR
// - Reset: busy=0, hi=0, lo=0, counter=0, pending result=0. Reset mid-op aborts it; HI/LO stay 0.
// - Accept: start && !req && !busy. Otherwise the op is dropped silently (no state change).
// - Hazard unit stalls on (start && is_muldiv) || busy; ex_mdu does not compute that term.
// - States: IDLE (busy=0), RUN (busy=1). IDLE->RUN on accepted mult/div; RUN->IDLE when counter hits 1.
// - Mult/div accepted at edge t: result computed from operands at t into pending regs,
//   counter loaded with N (MULT_CYCLES/DIV_CYCLES); busy=1 after edge t;
//   counter decrements each edge; at edge t+N hi/lo <= pending and busy <= 0 together.
// - mfhi/mflo see new values from cycle after edge t+N; nothing observable earlier.
// - MULT: {hi,lo} = signed(rs)*signed(rt), 64-bit. MULTU: unsigned 64-bit product.
// - DIV: lo = quotient truncated toward zero, hi = remainder with dividend's sign.
//   0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (no trap).
// - DIVU: unsigned quotient/remainder.
// - Divisor zero (DIV/DIVU): op still runs DIV_CYCLES with busy=1; hi/lo unchanged at completion.
// - MTHI/MTLO accepted (same accept rule): hi (resp. lo) <= rs_val at the same edge; busy stays 0.
// - MTHI/MTLO while busy: dropped (hazard unit prevents it; block guarantees no corruption).
// - req while RUN: in-flight op continues and commits; req only squashes the current cycle's issue.
// - start with undefined mdu_op: ignored.
// STRUCTURE
// - mdu_pkg: MDU_* op encodings, MDU_OP_W=3, default cycle counts, is_muldiv() helper.
// - One sub-module: mdu_timer (load N, decrement, done pulse at 1->0); rest lives in ex_mdu.
// - Arithmetic via single-cycle combinational * and /; latency is purely the modelled timer.
// TESTING
// - MULT rs=0xFFFFFFFD rt=2, start 1 cycle -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA.
// - DIV rs=0xFFFFFFF9(-7) rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 hi=1.
// - start=1 req=1 MULTU 3*4 -> busy never rises, hi/lo unchanged; same for MTHI with req=1.
// - DIVU by 0 after MTHI 0x12 / MTLO 0x34 -> busy 10 cycles, then hi=0x12 lo=0x34 unchanged.
// - MULT in flight, reset on cycle 3 -> next cycle busy=0 hi=0 lo=0; no late commit.
// - MTLO 0xAA while busy -> lo unaffected until completion, then equals product low word.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide unit.
`timescale 1ns/1ps
package mdu_pkg;

    localparam int MDU_OP_W            = 3;
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Encodings 6 and 7 are undefined and ignored by the unit.
    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_timer.sv
// Latency timer: load N, count down once per edge, done is high on the cycle
// whose closing edge takes the count from 1 to 0.
`timescale 1ns/1ps
module mdu_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d; a missing branch would infer a latch.
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: single-cycle arithmetic captured into pending
// registers, committed to HI/LO after a modelled MULT/DIV latency.
`timescale 1ns/1ps
module ex_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [31:0]         rs_val,
    input  logic [31:0]         rt_val,
    output logic                busy,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e state_q, state_d;

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic             accept, accept_muldiv, timer_done;
    logic [CNT_W-1:0] timer_val;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] sdiv_den, udiv_den;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;

    assign accept        = start && !req && !busy;
    assign accept_muldiv = accept && is_muldiv(mdu_op);
    assign timer_val     = is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    mdu_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_muldiv),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept_muldiv) state_d = MDU_RUN;
            MDU_RUN:  if (timer_done)    state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q == MDU_RUN);
    end

    // A zero divisor, and the one signed overflow case (INT_MIN / -1), divide by 1
    // instead: the first never commits, the second then yields exactly INT_MIN rem 0.
    always_comb begin
        prod_s   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        prod_u   = {32'd0, rs_val} * {32'd0, rt_val};
        sdiv_den = ((rt_val == 32'd0) || (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF))
                   ? 32'd1 : rt_val;
        udiv_den = (rt_val == 32'd0) ? 32'd1 : rt_val;
        quot_s   = $signed(rs_val) / $signed(sdiv_den);
        rem_s    = $signed(rs_val) % $signed(sdiv_den);
        quot_u   = rs_val / udiv_den;
        rem_u    = rs_val % udiv_den;
    end

    always_comb begin
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (timer_done && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end

        if (accept) begin
            case (mdu_op)
                MDU_MULT:  begin {pend_hi_d, pend_lo_d} = prod_s;          pend_wr_d = 1'b1; end
                MDU_MULTU: begin {pend_hi_d, pend_lo_d} = prod_u;          pend_wr_d = 1'b1; end
                MDU_DIV:   begin {pend_hi_d, pend_lo_d} = {rem_s, quot_s}; pend_wr_d = (rt_val != 32'd0); end
                MDU_DIVU:  begin {pend_hi_d, pend_lo_d} = {rem_u, quot_u}; pend_wr_d = (rt_val != 32'd0); end
                MDU_MTHI:  hi_d = rs_val;
                MDU_MTLO:  lo_d = rs_val;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
